// File: rtl/system_pkg.sv
// System-wide widths shared by the bus-facing blocks.
package system_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/instr_ahbl_bridge_if.sv
// Core fetch port plus AHB-Lite master port of the instruction bridge.
// Fetch handshake: instr_req_i/instr_addr_i are held until instr_gnt_o is seen
// high on a clock edge; each grant yields exactly one instr_rvalid_o pulse.
interface instr_ahbl_bridge_if;
  import system_pkg::*;

  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;
  logic                  instr_err_o;

  logic [ADDR_WIDTH-1:0] ahbl_haddr;
  logic [1:0]            ahbl_htrans;
  logic [2:0]            ahbl_hsize;
  logic [2:0]            ahbl_hburst;
  logic                  ahbl_hwrite;
  logic [DATA_WIDTH-1:0] ahbl_hwdata;
  logic [3:0]            ahbl_hprot;
  logic                  ahbl_hmastlock;
  logic [DATA_WIDTH-1:0] ahbl_hrdata;
  logic                  ahbl_hready;
  logic                  ahbl_hresp;

  // The bridge: slave to the core, master on AHB-Lite.
  modport master (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output ahbl_haddr, ahbl_htrans, ahbl_hsize, ahbl_hburst, ahbl_hwrite,
    output ahbl_hwdata, ahbl_hprot, ahbl_hmastlock,
    input  ahbl_hrdata, ahbl_hready, ahbl_hresp
  );

  // The environment: fetching core plus AHB-Lite slave.
  modport slave (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  ahbl_haddr, ahbl_htrans, ahbl_hsize, ahbl_hburst, ahbl_hwrite,
    input  ahbl_hwdata, ahbl_hprot, ahbl_hmastlock,
    output ahbl_hrdata, ahbl_hready, ahbl_hresp
  );
endinterface

// File: rtl/instr_ahbl_bridge.sv
// Instruction-fetch to AHB-Lite read bridge: one outstanding data phase,
// pipelined address phases, optional registered response.
module instr_ahbl_bridge #(
  parameter bit         REG_RSP   = 1'b1,
  parameter logic [3:0] HPROT_VAL = 4'b0010
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_ahbl_bridge_if.master  bus,
  output logic [1:0]           state_o
);
  localparam int AW = system_pkg::ADDR_WIDTH;
  localparam int DW = system_pkg::DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DPHASE = 2'd1,
    S_ERR    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            req_ok;
  logic            gnt;
  logic            cpl;
  logic            cpl_err;
  logic [DW-1:0]   cpl_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    // No address phase is issued in the second error cycle; the core's
    // request simply waits and is re-presented once ERR retires.
    req_ok    = bus.instr_req_i && (state_q != S_ERR);
    gnt       = req_ok && bus.ahbl_hready;
    cpl       = ((state_q == S_DPHASE) || (state_q == S_ERR)) && bus.ahbl_hready;
    cpl_err   = (state_q == S_ERR) || bus.ahbl_hresp;
    cpl_rdata = cpl_err ? '0 : bus.ahbl_hrdata;

    if (gnt) begin
      state_d = S_DPHASE;
    end else begin
      case (state_q)
        S_DPHASE: begin
          if (bus.ahbl_hready)     state_d = S_IDLE;
          else if (bus.ahbl_hresp) state_d = S_ERR;
        end
        S_ERR: begin
          if (bus.ahbl_hready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

  assign bus.instr_gnt_o    = gnt;
  assign bus.ahbl_htrans    = req_ok ? 2'b10 : 2'b00;
  // Word fetches only: byte offset bits are cleared.
  assign bus.ahbl_haddr     = {bus.instr_addr_i[AW-1:2], 2'b00};
  assign bus.ahbl_hsize     = 3'b010;
  assign bus.ahbl_hburst    = 3'b000;
  assign bus.ahbl_hwrite    = 1'b0;
  assign bus.ahbl_hwdata    = '0;
  assign bus.ahbl_hprot     = HPROT_VAL;
  assign bus.ahbl_hmastlock = 1'b0;

  generate
    if (REG_RSP) begin : g_reg_rsp
      logic          rvalid_q, rvalid_d;
      logic          err_q, err_d;
      logic [DW-1:0] rdata_q, rdata_d;

      always_comb begin
        rvalid_d = cpl;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (cpl) begin
          err_d   = cpl_err;
          rdata_d = cpl_rdata;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= rvalid_d;
          err_q    <= err_d;
          rdata_q  <= rdata_d;
        end
      end

      assign bus.instr_rvalid_o = rvalid_q;
      assign bus.instr_err_o    = err_q;
      assign bus.instr_rdata_o  = rdata_q;
    end else begin : g_comb_rsp
      assign bus.instr_rvalid_o = cpl;
      assign bus.instr_err_o    = cpl && cpl_err;
      assign bus.instr_rdata_o  = cpl ? cpl_rdata : '0;
    end
  endgenerate
endmodule
